// File: rtl/axi_stream_packet_arbiter_pkg.sv
// Shared types and round-robin helper for the AXI stream packet arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / LOCKED)
//   next_rr     : first requesting index after ptr, wrapping modulo num_ports
package stream_arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  // Upper bound on requester count handled by next_rr.
  localparam int unsigned MAX_PORTS = 64;

  function automatic int unsigned next_rr(
    input int unsigned          ptr,
    input logic [MAX_PORTS-1:0] req,
    input int unsigned          num_ports
  );
    int unsigned winner;
    int unsigned idx;
    logic        found;
    winner = 0;
    found  = 1'b0;
    // Scan ptr+1, ptr+2, ... so the last winner has the lowest priority.
    for (int unsigned k = 1; k <= num_ports; k++) begin
      idx = (ptr + k) % num_ports;
      if (!found && req[idx[5:0]]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    return winner;
  endfunction

endpackage

// File: rtl/axi_stream_packet_arbiter_rr_priority_select.sv
// Combinational round-robin priority selector.
//   req       : per-requester request vector
//   ptr       : index of the previous winner (lowest priority this round)
//   grant_idx : first requester after ptr; 0 when no request
//   any_req   : OR of req
module rr_priority_select
  import stream_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ID_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  ptr,
  output logic [ID_WIDTH-1:0]  grant_idx,
  output logic                 any_req
);

  logic [MAX_PORTS-1:0] req_ext;

  always_comb begin
    req_ext                 = '0;
    req_ext[NUM_PORTS-1:0]  = req;
    grant_idx               = ID_WIDTH'(next_rr(32'(ptr), req_ext, NUM_PORTS));
    any_req                 = |req;
  end

endmodule

// File: rtl/axi_stream_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI stream sink.
//   clk, rst                 : clock, async active-high reset
//   in_tvalid/tready/tlast   : per-port handshake and last (NUM_PORTS wide)
//   in_tdata / in_tkeep      : packed per-port data / keep
//   out_tvalid/tdata/tkeep/tlast/tid : registered output beat and source index
//   out_tready               : sink ready
//   busy                     : a packet is locked or an output beat is pending
// A granted port keeps the grant until its tlast beat is accepted.
module axi_stream_packet_arbiter
  import stream_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             in_tvalid,
  output logic [NUM_PORTS-1:0]             in_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  in_tkeep,
  input  logic [NUM_PORTS-1:0]             in_tlast,
  output logic                             out_tvalid,
  input  logic                             out_tready,
  output logic [DATA_WIDTH-1:0]            out_tdata,
  output logic [KEEP_WIDTH-1:0]            out_tkeep,
  output logic                             out_tlast,
  output logic [ID_WIDTH-1:0]              out_tid,
  output logic                             busy
);

  localparam logic [ID_WIDTH-1:0] RR_RESET = ID_WIDTH'(NUM_PORTS - 1);

  arb_state_t            state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   win_idx;
  logic                  any_req;
  logic                  accept;
  logic                  sel_tlast;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic [KEEP_WIDTH-1:0] sel_tkeep;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_select (
    .req       (in_tvalid),
    .ptr       (rr_ptr_q),
    .grant_idx (win_idx),
    .any_req   (any_req)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    in_tready = '0;
    accept    = 1'b0;
    sel_tdata = in_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    sel_tkeep = in_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
    sel_tlast = in_tlast[grant_q];
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = win_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        // Ready depends only on the output register, never on in_tvalid.
        in_tready[grant_q] = !out_tvalid || out_tready;
        accept             = in_tvalid[grant_q] && in_tready[grant_q];
        if (accept && sel_tlast) begin
          state_d  = IDLE;
          rr_ptr_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= RR_RESET;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tlast  <= 1'b0;
      out_tid    <= '0;
    end else if (accept) begin
      out_tvalid <= 1'b1;
      out_tdata  <= sel_tdata;
      out_tkeep  <= sel_tkeep;
      out_tlast  <= sel_tlast;
      out_tid    <= grant_q;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

  assign busy = (state_q == LOCKED) || out_tvalid;

endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// Directed and randomized checks for axi_stream_packet_arbiter (4 ports, 32-bit data).
module tb_axi_stream_packet_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_tvalid, in_tready, in_tlast;
  logic [127:0] in_tdata;
  logic [15:0]  in_tkeep;
  logic         out_tvalid, out_tready, out_tlast, busy;
  logic [31:0]  out_tdata;
  logic [3:0]   out_tkeep;
  logic [1:0]   out_tid;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  axi_stream_packet_arbiter #(
    .NUM_PORTS  (4),
    .DATA_WIDTH (32),
    .KEEP_WIDTH (4),
    .ID_WIDTH   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tdata   (in_tdata),
    .in_tkeep   (in_tkeep),
    .in_tlast   (in_tlast),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tlast  (out_tlast),
    .out_tid    (out_tid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic [31:0] d,
                       input logic [3:0] k, input logic l);
    in_tvalid[p]         = v;
    in_tdata[p*32 +: 32] = d;
    in_tkeep[p*4 +: 4]   = k;
    in_tlast[p]          = l;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_tvalid  = '0;
    in_tdata   = '0;
    in_tkeep   = '0;
    in_tlast   = '0;
    out_tready = 1'b1;
    tick();
    tick();
    check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    check("rst_in_tready", 64'(in_tready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_tdata", 64'(out_tdata), 64'd0);
    check("rst_out_tid", 64'(out_tid), 64'd0);
    rst = 1'b0;
  endtask

  function automatic int unsigned pkt_len(input int unsigned p, input int unsigned n);
    return (p + n) % 3 + 1;
  endfunction

  initial begin
    logic [31:0]  held;
    logic [31:0]  sb[$];
    logic         fire_in3, fire_out;
    logic [3:0]   fire_in, vld;
    int unsigned  idx;
    int unsigned  pkt[4], beat[4], exp_pkt[4], exp_beat[4], wait_cnt[4], max_wait[4];
    int unsigned  cur, t;
    logic         in_pkt;

    // ---- single 3-beat packet on port 2 ----
    do_reset();
    drive(2, 1'b1, 32'hD0D0_0000, 4'hF, 1'b0);
    check("t1_c0_out_tvalid", 64'(out_tvalid), 64'd0);
    tick();
    check("t1_c1_in_tready", 64'(in_tready), 64'h4);
    check("t1_c1_out_tvalid", 64'(out_tvalid), 64'd0);
    check("t1_c1_busy", 64'(busy), 64'd1);
    tick();
    check("t1_c2_out_tvalid", 64'(out_tvalid), 64'd1);
    check("t1_c2_out_tdata", 64'(out_tdata), 64'hD0D0_0000);
    check("t1_c2_out_tid", 64'(out_tid), 64'd2);
    check("t1_c2_out_tlast", 64'(out_tlast), 64'd0);
    drive(2, 1'b1, 32'hD0D0_0001, 4'hF, 1'b0);
    tick();
    check("t1_c3_out_tdata", 64'(out_tdata), 64'hD0D0_0001);
    check("t1_c3_out_tlast", 64'(out_tlast), 64'd0);
    drive(2, 1'b1, 32'hD0D0_0002, 4'h7, 1'b1);
    tick();
    check("t1_c4_out_tvalid", 64'(out_tvalid), 64'd1);
    check("t1_c4_out_tdata", 64'(out_tdata), 64'hD0D0_0002);
    check("t1_c4_out_tkeep", 64'(out_tkeep), 64'h7);
    check("t1_c4_out_tlast", 64'(out_tlast), 64'd1);
    check("t1_c4_in_tready", 64'(in_tready), 64'd0);
    drive(2, 1'b0, 32'h0, 4'h0, 1'b0);
    tick();
    check("t1_c5_out_tvalid", 64'(out_tvalid), 64'd0);
    check("t1_c5_busy", 64'(busy), 64'd0);

    // ---- all ports valid, single-beat packets: rotation 0,1,2,3,0 ----
    do_reset();
    for (int p = 0; p < 4; p++) drive(p, 1'b1, 32'(32'hA0 + p), 4'hF, 1'b1);
    tick();
    check("t2_c1_in_tready", 64'(in_tready), 64'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_beat_valid", 64'(out_tvalid), 64'd1);
      check("t2_beat_tid", 64'(out_tid), 64'(k % 4));
      check("t2_beat_tdata", 64'(out_tdata), 64'(32'hA0 + (k % 4)));
      tick();
      check("t2_bubble_valid", 64'(out_tvalid), 64'd0);
    end

    // ---- port 1 holds the grant across a tvalid gap while port 0 waits ----
    do_reset();
    drive(1, 1'b1, 32'hB000_0000, 4'hF, 1'b0);
    tick();
    check("t3_c1_in_tready", 64'(in_tready), 64'h2);
    drive(0, 1'b1, 32'hC000_0000, 4'hF, 1'b1);
    tick();
    check("t3_c2_out_tdata", 64'(out_tdata), 64'hB000_0000);
    check("t3_c2_out_tid", 64'(out_tid), 64'd1);
    drive(1, 1'b1, 32'hB000_0001, 4'hF, 1'b0);
    tick();
    check("t3_c3_out_tdata", 64'(out_tdata), 64'hB000_0001);
    drive(1, 1'b0, 32'hB000_0002, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_gap_out_tvalid", 64'(out_tvalid), 64'd0);
      check("t3_gap_in_tready", 64'(in_tready), 64'h2);
      check("t3_gap_busy", 64'(busy), 64'd1);
    end
    drive(1, 1'b1, 32'hB000_0002, 4'hF, 1'b0);
    tick();
    check("t3_c7_out_tdata", 64'(out_tdata), 64'hB000_0002);
    check("t3_c7_out_tid", 64'(out_tid), 64'd1);
    check("t3_c7_in_tready", 64'(in_tready), 64'h2);
    drive(1, 1'b1, 32'hB000_0003, 4'hF, 1'b1);
    tick();
    check("t3_c8_out_tdata", 64'(out_tdata), 64'hB000_0003);
    check("t3_c8_out_tlast", 64'(out_tlast), 64'd1);
    check("t3_c8_in_tready", 64'(in_tready), 64'd0);
    drive(1, 1'b0, 32'h0, 4'h0, 1'b0);
    tick();
    check("t3_c9_in_tready", 64'(in_tready), 64'h1);
    check("t3_c9_out_tvalid", 64'(out_tvalid), 64'd0);
    tick();
    check("t3_c10_out_tdata", 64'(out_tdata), 64'hC000_0000);
    check("t3_c10_out_tid", 64'(out_tid), 64'd0);
    drive(0, 1'b0, 32'h0, 4'h0, 1'b0);

    // ---- backpressure: out_tready low for 5 cycles mid-packet ----
    do_reset();
    idx  = 0;
    held = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_tready = !(cyc >= 3 && cyc < 8);
      drive(3, idx < 6, 32'(32'hE000 + idx), 4'hF, idx == 5);
      #1;
      if (cyc == 3) begin
        held = out_tdata;
        check("t4_stall_beat", 64'(held), 64'hE001);
      end
      if (cyc >= 3 && cyc < 8) begin
        check("t4_stall_out_tvalid", 64'(out_tvalid), 64'd1);
        check("t4_stall_in_tready", 64'(in_tready), 64'd0);
        if (cyc > 3) check("t4_stall_tdata_held", 64'(out_tdata), 64'(held));
      end
      fire_in3 = in_tvalid[3] & in_tready[3];
      fire_out = out_tvalid & out_tready;
      if (fire_out) sb.push_back(out_tdata);
      tick();
      if (fire_in3) idx++;
    end
    check("t4_beat_count", 64'(sb.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < sb.size()) check("t4_beat_order", 64'(sb[i]), 64'(32'hE000 + i));
    end

    // ---- reset mid-packet, then port 0 wins first ----
    out_tready = 1'b1;
    drive(2, 1'b1, 32'hF000_0000, 4'hF, 1'b0);
    tick();
    check("t5_c1_in_tready", 64'(in_tready), 64'h4);
    tick();
    check("t5_c2_out_tdata", 64'(out_tdata), 64'hF000_0000);
    check("t5_c2_out_tid", 64'(out_tid), 64'd2);
    drive(2, 1'b1, 32'hF000_0001, 4'hF, 1'b0);
    drive(0, 1'b1, 32'h0000_600D, 4'hF, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_async_out_tvalid", 64'(out_tvalid), 64'd0);
    check("t5_async_in_tready", 64'(in_tready), 64'd0);
    check("t5_async_busy", 64'(busy), 64'd0);
    tick();
    check("t5_rst_out_tvalid", 64'(out_tvalid), 64'd0);
    check("t5_rst_in_tready", 64'(in_tready), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();
    check("t5_post_in_tready", 64'(in_tready), 64'h1);
    tick();
    check("t5_post_out_tdata", 64'(out_tdata), 64'h0000_600D);
    check("t5_post_out_tid", 64'(out_tid), 64'd0);

    // ---- random traffic: contiguity, order, fairness ----
    do_reset();
    vld    = '0;
    cur    = 0;
    in_pkt = 1'b0;
    for (int p = 0; p < 4; p++) begin
      pkt[p] = 0; beat[p] = 0; exp_pkt[p] = 0; exp_beat[p] = 0;
      wait_cnt[p] = 0; max_wait[p] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      out_tready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 4; p++) begin
        if (!vld[p] && $urandom_range(0, 2) == 0) vld[p] = 1'b1;
        drive(p, vld[p], {8'(p), 12'(pkt[p]), 12'(beat[p])}, 4'hF,
              beat[p] == pkt_len(p, pkt[p]) - 1);
      end
      #1;
      fire_in  = in_tvalid & in_tready;
      fire_out = out_tvalid & out_tready;
      if (fire_out) begin
        t = 32'(out_tid);
        if (in_pkt) check("t6_contiguous", 64'(out_tid), 64'(cur));
        check("t6_tdata", 64'(out_tdata), 64'({8'(t), 12'(exp_pkt[t]), 12'(exp_beat[t])}));
        check("t6_tlast", 64'(out_tlast), 64'(exp_beat[t] == pkt_len(t, exp_pkt[t]) - 1));
        if (exp_beat[t] == pkt_len(t, exp_pkt[t]) - 1) begin
          exp_pkt[t]++;
          exp_beat[t] = 0;
        end else begin
          exp_beat[t]++;
        end
        in_pkt = !out_tlast;
        cur    = t;
      end
      for (int q = 0; q < 4; q++) begin
        if (fire_in[q] && in_tlast[q]) begin
          for (int p = 0; p < 4; p++) begin
            if (p != q && vld[p]) begin
              wait_cnt[p]++;
              if (wait_cnt[p] > max_wait[p]) max_wait[p] = wait_cnt[p];
            end
          end
        end
      end
      tick();
      for (int p = 0; p < 4; p++) begin
        if (fire_in[p]) begin
          wait_cnt[p] = 0;
          if (beat[p] == pkt_len(p, pkt[p]) - 1) begin
            pkt[p]++;
            beat[p] = 0;
          end else begin
            beat[p]++;
          end
          vld[p] = 1'($urandom_range(0, 1));
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      check("t6_no_starvation", 64'(max_wait[p] <= 3), 64'd1);
      check("t6_progress", 64'(exp_pkt[p] > 10), 64'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
